// File: rtl/serial_deser4.sv
// Serial-in / parallel-out receiver: frames WIDTH-bit words on a sync strobe and
// presents each completed word through a one-word valid/ready holding buffer.
module serial_deser4 #(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sin,
   input  logic             sin_en,
   input  logic             sync,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   input  logic             dout_ready,
   output logic             busy,
   output logic             overrun,
   output logic             frame_err,
   input  logic             clr_err
);

   // Handshake: a word transfers on an edge where dout_valid=1 and dout_ready=1;
   // dout and dout_valid hold steady until that happens.

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

   state_t           state, state_nx;
   logic [CW-1:0]    cnt, cnt_nx;
   logic [WIDTH-1:0] sr, sr_nx, sr_shift, sr_first;
   logic             word_done, frame_resync;
   logic             drain, load;

   always_comb begin
      sr_shift = MSB_FIRST ? {sr[WIDTH-2:0], sin} : {sin, sr[WIDTH-1:1]};
      sr_first = MSB_FIRST ? {{(WIDTH-1){1'b0}}, sin} : {sin, {(WIDTH-1){1'b0}}};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         sr    <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         sr    <= sr_nx;
      end
   end

   always_comb begin
      state_nx     = state;
      cnt_nx       = cnt;
      sr_nx        = sr;
      word_done    = 1'b0;
      frame_resync = 1'b0;
      if (sin_en) begin
         case (state)
            IDLE: begin
               if (sync) begin
                  sr_nx    = sr_first;
                  cnt_nx   = CW'(1);
                  state_nx = SHIFT;
               end
            end
            SHIFT: begin
               if (sync) begin
                  frame_resync = 1'b1;
                  sr_nx        = sr_first;
                  cnt_nx       = CW'(1);
               end else begin
                  sr_nx = sr_shift;
                  if (cnt == CW'(WIDTH - 1)) begin
                     word_done = 1'b1;
                     cnt_nx    = '0;
                     state_nx  = IDLE;
                  end else begin
                     cnt_nx = cnt + 1'b1;
                  end
               end
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   assign drain = dout_valid & dout_ready;
   // A completed word may enter the buffer on the same edge the old one leaves.
   assign load  = word_done & (~dout_valid | dout_ready);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout       <= '0;
         dout_valid <= 1'b0;
         overrun    <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         if (load) begin
            dout       <= sr_shift;
            dout_valid <= 1'b1;
         end else if (drain) begin
            dout_valid <= 1'b0;
         end
         overrun   <= (word_done & ~load) | (overrun & ~clr_err);
         frame_err <= frame_resync | (frame_err & ~clr_err);
      end
   end

   assign busy = (state == SHIFT);

endmodule
